// File: rtl/bcd_disp_pkg.sv
// Shared constants for the two-digit BCD display multiplexer:
// active-high segment codes (gfedcba), digit-enable codes and digit-select encoding.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [1:0] AN_ONES  = 2'b01;
    localparam logic [1:0] AN_TENS  = 2'b10;
    localparam logic [1:0] AN_NONE  = 2'b00;

    localparam logic [3:0] BCD_MAX  = 4'd9;

    typedef enum logic {
        SEL_ONES = 1'b0,
        SEL_TENS = 1'b1
    } sel_e;

    function automatic logic nib_invalid(input logic [3:0] nib);
        return nib > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high seven-segment decoder.
// Non-decimal nibbles show a dash and raise invalid_o.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o,
    output logic       invalid_o
);

    always_comb begin
        invalid_o = nib_invalid(nib_i);
        case (nib_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed seven-segment driver: synchronises the external BCD count,
// latches it only when stable, and scans ones/tens digits at REFRESH_DIV cycles per phase.
module bcd_display_mux
    import bcd_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          BLANK_LZ       = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] count,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic       invalid
);

    localparam int unsigned    CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
    // XOR masks turn active-high codes into the configured drive polarity.
    localparam logic [6:0]     SEG_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]     AN_MASK  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic           DP_OFF   = SEG_ACTIVE_LOW;

    logic [7:0]    sync1_q, sync2_q;
    logic [7:0]    disp_val_q, disp_val_d;
    logic [CW-1:0] cnt_q, cnt_d;
    sel_e          sel_q, sel_d;

    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          dp_q;
    logic          inv_q, inv_d;

    logic [3:0]    nib_sel, nib_other;
    logic [6:0]    dec_seg;
    logic          dec_inv;
    logic          blank;
    logic [6:0]    seg_hi;
    logic [1:0]    an_hi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            disp_val_q <= '0;
        end else begin
            sync1_q    <= count;
            sync2_q    <= sync1_q;
            disp_val_q <= disp_val_d;
        end
    end

    // A value still moving through the synchroniser is never latched.
    always_comb begin
        disp_val_d = disp_val_q;
        if (sync1_q == sync2_q) begin
            disp_val_d = sync2_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sel_q <= SEL_ONES;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        sel_d = sel_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            sel_d = (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
        end
    end

    always_comb begin
        if (sel_q == SEL_TENS) begin
            nib_sel   = disp_val_q[7:4];
            nib_other = disp_val_q[3:0];
        end else begin
            nib_sel   = disp_val_q[3:0];
            nib_other = disp_val_q[7:4];
        end
    end

    bcd_to_seg7 u_dec (
        .nib_i     (nib_sel),
        .seg_o     (dec_seg),
        .invalid_o (dec_inv)
    );

    always_comb begin
        blank  = BLANK_LZ && (sel_q == SEL_TENS) && (disp_val_q[7:4] == 4'h0);
        seg_hi = blank ? SEG_OFF : dec_seg;
        if (blank) begin
            an_hi = AN_NONE;
        end else begin
            an_hi = (sel_q == SEL_TENS) ? AN_TENS : AN_ONES;
        end
        seg_d = seg_hi ^ SEG_MASK;
        an_d  = an_hi ^ AN_MASK;
        // invalid covers both nibbles regardless of which digit is being scanned.
        inv_d = dec_inv | nib_invalid(nib_other);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q <= SEG_MASK;
            an_q  <= AN_MASK;
            dp_q  <= DP_OFF;
            inv_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= DP_OFF;
            inv_q <= inv_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign dp      = dp_q;
    assign invalid = inv_q;

endmodule
